// File: rtl/tcm_ctrl_pkg.sv
// Shared constants for the TCM capture controller: FSM encoding, TCM geometry
// and the round-robin owner encoding used by the port arbiter.
package tcm_ctrl_pkg;

    localparam int TCM_ADDR_WIDTH = 5;
    localparam int TCM_DEPTH      = 2 ** TCM_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic OWNER_STREAM = 1'b0;
    localparam logic OWNER_READ   = 1'b1;

endpackage

// File: rtl/tcm_port_arbiter.sv
// Round-robin owner of the single TCM port (stream write vs. register readback)
// with a fully registered port and a three-stage readback return path.
module tcm_port_arbiter
    import tcm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = TCM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stream_en,
    input  logic                  stream_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  stream_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  tcm_en,
    output logic                  tcm_we,
    output logic [ADDR_WIDTH-1:0] tcm_addr,
    output logic [DATA_WIDTH-1:0] tcm_wdata,
    input  logic [DATA_WIDTH-1:0] tcm_rdata
);

    // Handshakes: a stream beat transfers in any cycle where stream_valid and
    // stream_ready are both high; a read transfers in the cycle rd_gnt is high
    // (rd_req held until then). Exactly one transfer may win a given cycle.
    logic last_owner;
    logic rd_s1;
    logic rd_s2;
    logic rd_pending;
    logic stream_want;
    logic beat;

    assign rd_pending   = rd_s1 | rd_s2;
    assign stream_want  = stream_en & stream_valid;
    assign rd_gnt       = rd_req & ~rst & ~rd_pending &
                          ((last_owner == OWNER_STREAM) | ~stream_want);
    assign stream_ready = stream_en & ~rd_gnt;
    assign beat         = stream_want & stream_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWNER_STREAM;
            rd_s1      <= 1'b0;
            rd_s2      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            tcm_en     <= 1'b0;
            tcm_we     <= 1'b0;
            tcm_addr   <= '0;
            tcm_wdata  <= '0;
        end else begin
            tcm_en   <= beat | rd_gnt;
            tcm_we   <= beat;
            rd_s1    <= rd_gnt;
            rd_s2    <= rd_s1;
            rd_valid <= rd_s2;
            if (rd_s2) begin
                rd_data <= tcm_rdata;
            end
            // Address/data hold between accesses so the port only toggles on use.
            if (beat) begin
                tcm_addr   <= wr_addr;
                tcm_wdata  <= wr_data;
                last_owner <= OWNER_STREAM;
            end else if (rd_gnt) begin
                tcm_addr   <= rd_addr;
                last_owner <= OWNER_READ;
            end
        end
    end

endmodule

// File: rtl/tcm_capture_arbiter.sv
// Frame-capture controller for the stream-slave TCM with shared readback port.
// Build option TCM_CAPTURE_WRAP_EN: write pointer wraps and capture runs to TLAST.
module tcm_capture_arbiter
    import tcm_ctrl_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_TCM_ADDR_WIDTH     = TCM_ADDR_WIDTH
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESET,
    input  logic                            ctrl_start,
    input  logic                            ctrl_rd_req,
    input  logic [C_TCM_ADDR_WIDTH-1:0]     ctrl_rd_addr,
    output logic                            ctrl_rd_gnt,
    output logic                            ctrl_rd_valid,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] ctrl_rd_data,
    output logic                            stat_busy,
    output logic                            stat_done,
    output logic                            stat_overflow,
    output logic [C_TCM_ADDR_WIDTH:0]       stat_count,
    input  logic                            S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic                            tcm_en,
    output logic                            tcm_we,
    output logic [C_TCM_ADDR_WIDTH-1:0]     tcm_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] tcm_wdata,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] tcm_rdata
);

    localparam logic [C_TCM_ADDR_WIDTH:0] COUNT_FULL = {1'b1, {C_TCM_ADDR_WIDTH{1'b0}}};
    localparam logic [C_TCM_ADDR_WIDTH:0] COUNT_LAST = COUNT_FULL - 1'b1;

    logic [1:0]                  state;
    logic [C_TCM_ADDR_WIDTH-1:0] wptr;
    logic                        stream_en;
    logic                        beat;

    // A start pulse holds off the stream for one cycle so no beat lands at the
    // old pointer while the counters are being cleared.
    assign stream_en = (state == ST_CAPTURE) & ~ctrl_start & ~S_AXIS_ARESET;
    assign beat      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign stat_busy = (state == ST_CAPTURE);
    assign stat_done = (state == ST_DONE);

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state         <= ST_IDLE;
            wptr          <= '0;
            stat_count    <= '0;
            stat_overflow <= 1'b0;
        end else if (ctrl_start) begin
            state         <= ST_CAPTURE;
            wptr          <= '0;
            stat_count    <= '0;
            stat_overflow <= 1'b0;
        end else if (beat) begin
            wptr <= wptr + 1'b1;
`ifdef TCM_CAPTURE_WRAP_EN
            if (stat_count != COUNT_FULL) begin
                stat_count <= stat_count + 1'b1;
            end
            if ((&wptr) && !S_AXIS_TLAST) begin
                stat_overflow <= 1'b1;
            end
            if (S_AXIS_TLAST) begin
                state <= ST_DONE;
            end
`else
            stat_count <= stat_count + 1'b1;
            if ((stat_count == COUNT_LAST) && !S_AXIS_TLAST) begin
                stat_overflow <= 1'b1;
            end
            if (S_AXIS_TLAST || (stat_count == COUNT_LAST)) begin
                state <= ST_DONE;
            end
`endif
        end
    end

    tcm_port_arbiter #(
        .DATA_WIDTH (C_S_AXIS_TDATA_WIDTH),
        .ADDR_WIDTH (C_TCM_ADDR_WIDTH)
    ) u_port_arbiter (
        .clk          (S_AXIS_ACLK),
        .rst          (S_AXIS_ARESET),
        .stream_en    (stream_en),
        .stream_valid (S_AXIS_TVALID),
        .wr_addr      (wptr),
        .wr_data      (S_AXIS_TDATA),
        .rd_req       (ctrl_rd_req),
        .rd_addr      (ctrl_rd_addr),
        .rd_gnt       (ctrl_rd_gnt),
        .stream_ready (S_AXIS_TREADY),
        .rd_valid     (ctrl_rd_valid),
        .rd_data      (ctrl_rd_data),
        .tcm_en       (tcm_en),
        .tcm_we       (tcm_we),
        .tcm_addr     (tcm_addr),
        .tcm_wdata    (tcm_wdata),
        .tcm_rdata    (tcm_rdata)
    );

endmodule

// File: tb/tb_tcm_capture_arbiter.sv
// Bench for tcm_capture_arbiter: directed capture/readback scenarios, a TCM RAM
// model, and a cycle-level reference model checked on every falling edge.
module tb_tcm_capture_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_start;
    logic        ctrl_rd_req;
    logic [4:0]  ctrl_rd_addr;
    logic        ctrl_rd_gnt;
    logic        ctrl_rd_valid;
    logic [31:0] ctrl_rd_data;
    logic        stat_busy;
    logic        stat_done;
    logic        stat_overflow;
    logic [5:0]  stat_count;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tready;
    logic        tcm_en;
    logic        tcm_we;
    logic [4:0]  tcm_addr;
    logic [31:0] tcm_wdata;
    logic [31:0] tcm_rdata;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    tcm_capture_arbiter dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .ctrl_start    (ctrl_start),
        .ctrl_rd_req   (ctrl_rd_req),
        .ctrl_rd_addr  (ctrl_rd_addr),
        .ctrl_rd_gnt   (ctrl_rd_gnt),
        .ctrl_rd_valid (ctrl_rd_valid),
        .ctrl_rd_data  (ctrl_rd_data),
        .stat_busy     (stat_busy),
        .stat_done     (stat_done),
        .stat_overflow (stat_overflow),
        .stat_count    (stat_count),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .tcm_en        (tcm_en),
        .tcm_we        (tcm_we),
        .tcm_addr      (tcm_addr),
        .tcm_wdata     (tcm_wdata),
        .tcm_rdata     (tcm_rdata)
    );

    // ---------------- clock / TCM RAM ----------------
    always #5 clk = ~clk;

    logic [31:0] ram [32];
    always @(posedge clk) begin
        if (tcm_en) begin
            if (tcm_we) ram[tcm_addr] <= tcm_wdata;
            else        tcm_rdata     <= ram[tcm_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 capture, 2 done. m_pcnt counts down to the readback strobe.
    int          m_state = 0;
    int          m_count = 0;
    int          m_wptr = 0;
    bit          m_ovf = 0;
    bit          m_owner_read = 0;
    int          m_pcnt = 0;
    logic [31:0] m_pdat = '0;
    logic [4:0]  m_raddr = '0;
    logic [31:0] m_rd_data = '0;
    bit          w_exp = 0;
    int          w_addr = 0;
    logic [31:0] w_data = '0;
    bit          armed = 0;
    bit          after_rst = 0;
    logic [31:0] shadow [32];

    always @(negedge clk) begin
        bit e_want, e_gnt, e_rdy, beat;
        e_want = tvalid && (m_state == 1) && !ctrl_start && !rst;
        e_gnt  = ctrl_rd_req && !rst && (m_pcnt < 2) && (!m_owner_read || !e_want);
        e_rdy  = (m_state == 1) && !rst && !ctrl_start && !e_gnt;
        if (ctrl_rd_valid === 1'b1) valid_cnt++;
        if (armed) begin
            chk("busy", stat_busy, m_state == 1);
            chk("done", stat_done, m_state == 2);
            chk("overflow", stat_overflow, m_ovf);
            chk("count", stat_count, m_count);
            chk("rd_gnt", ctrl_rd_gnt, e_gnt);
            chk("tready", tready, e_rdy);
            chk("rd_valid", ctrl_rd_valid, m_pcnt == 1);
            chk("rd_data", ctrl_rd_data, (m_pcnt == 1) ? m_pdat : m_rd_data);
            chk("tcm_en", tcm_en, w_exp || (m_pcnt == 3));
            if (w_exp) begin
                chk("tcm_we_w", tcm_we, 1);
                chk("tcm_addr_w", tcm_addr, w_addr);
                chk("tcm_wdata", tcm_wdata, w_data);
            end else if (m_pcnt == 3) begin
                chk("tcm_we_r", tcm_we, 0);
                chk("tcm_addr_r", tcm_addr, m_raddr);
            end
            if (after_rst) begin
                chk("tcm_addr_rst", tcm_addr, 0);
                chk("tcm_wdata_rst", tcm_wdata, 0);
            end
        end
        if (rst) begin
            m_state = 0; m_count = 0; m_wptr = 0; m_ovf = 0; m_owner_read = 0;
            m_pcnt = 0; m_rd_data = '0; w_exp = 0;
            armed = 1; after_rst = 1;
        end else begin
            after_rst = 0;
            w_exp = 0;
            if (m_pcnt == 1) m_rd_data = m_pdat;
            if (m_pcnt > 0) m_pcnt--;
            beat = tvalid && e_rdy;
            if (ctrl_start) begin
                m_state = 1; m_count = 0; m_wptr = 0; m_ovf = 0;
            end else if (beat) begin
                w_exp = 1; w_addr = m_wptr; w_data = tdata;
                shadow[m_wptr] = tdata;
                m_owner_read = 0;
`ifdef TCM_CAPTURE_WRAP_EN
                if (m_wptr == 31 && !tlast) m_ovf = 1;
                if (m_count < 32) m_count++;
                if (tlast) m_state = 2;
`else
                m_count++;
                if (m_count == 32 && !tlast) m_ovf = 1;
                if (tlast || m_count == 32) m_state = 2;
`endif
                m_wptr = (m_wptr + 1) % 32;
            end
            if (e_gnt) begin
                m_pcnt = 3; m_raddr = ctrl_rd_addr; m_pdat = shadow[ctrl_rd_addr];
                m_owner_read = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ctrl_start = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input int budget, output logic ok);
        logic acc;
        tvalid = 1'b1; tdata = d; tlast = l; ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output int lat, output int vlat, output logic [31:0] d);
        lat = -1; vlat = -1; d = '0;
        ctrl_rd_req = 1'b1; ctrl_rd_addr = a;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ctrl_rd_gnt) begin
                lat = c;
                break;
            end
        end
        @(posedge clk); #1;
        ctrl_rd_req = 1'b0;
        if (lat >= 0) begin
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (ctrl_rd_valid) begin
                    vlat = c; d = ctrl_rd_data;
                    break;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic ok;
        int lat, vlat;
        logic [31:0] d;
        int vbefore;
        rst = 1'b1; ctrl_start = 1'b0; ctrl_rd_req = 1'b0; ctrl_rd_addr = '0;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(1);
        chk("reset_count", stat_count, 0);
        chk("reset_tready", tready, 0);

        // 8-beat frame terminated by TLAST
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_beat(32'hA0 + i, i == 7, 20, ok);
            chk("t1_acc", ok, 1);
        end
        idle_cycles(2);
        for (int i = 0; i < 8; i++) chk("t1_ram", ram[i], 32'hA0 + i);
        chk("t1_done", stat_done, 1);
        chk("t1_count", stat_count, 8);
        chk("t1_ovf", stat_overflow, 0);
        tvalid = 1'b1;
        @(negedge clk);
        chk("t1_tready_after", tready, 0);
        @(posedge clk); #1;
        tvalid = 1'b0;

        // Stream with readback of address 3 interleaved
        pulse_start();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send_beat(32'hE0 + i, i == 19, 20, ok);
                    chk("t2_acc", ok, 1);
                    tvalid = 1'b1;
                end
                tvalid = 1'b0;
            end
            begin
                for (int r = 0; r < 4; r++) begin
                    do_read(5'd3, lat, vlat, d);
                    chk("t2_gnt_in_2", (lat >= 0 && lat <= 2), 1);
                    chk("t2_valid_lat", vlat, 3);
                    if (r == 0) chk("t2_first_data", d, 32'hA3);
                    idle_cycles(2);
                end
            end
        join
        idle_cycles(3);
        for (int i = 0; i < 20; i++) chk("t2_ram", ram[i], 32'hE0 + i);
        chk("t2_count", stat_count, 20);
        chk("t2_done", stat_done, 1);

        // Restart mid-capture
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_beat(32'hF0 + i, 1'b0, 20, ok);
            chk("t3_acc", ok, 1);
        end
        pulse_start();
        send_beat(32'h50, 1'b0, 20, ok);
        chk("t3_count_restart", stat_count, 1);
        send_beat(32'h51, 1'b0, 20, ok);
        send_beat(32'h52, 1'b1, 20, ok);
        idle_cycles(2);
        chk("t3_ram0", ram[0], 32'h50);
        chk("t3_ram2", ram[2], 32'h52);
        chk("t3_ram3", ram[3], 32'hF3);
        chk("t3_count", stat_count, 3);

        // 40-beat frame without an early TLAST
        pulse_start();
`ifdef TCM_CAPTURE_WRAP_EN
        for (int i = 0; i < 40; i++) begin
            send_beat(32'h100 + i, i == 39, 20, ok);
            chk("t4_acc", ok, 1);
        end
        idle_cycles(2);
        for (int i = 0; i < 8; i++) chk("t4_wrap_ram", ram[i], 32'h100 + 32 + i);
        chk("t4_ram31", ram[31], 32'h11F);
`else
        for (int i = 0; i < 40; i++) begin
            send_beat(32'h100 + i, 1'b0, (i < 32) ? 20 : 3, ok);
            chk((i < 32) ? "t4_acc" : "t4_stall", ok, i < 32);
        end
        idle_cycles(2);
        chk("t4_ram0", ram[0], 32'h100);
        chk("t4_ram31", ram[31], 32'h11F);
`endif
        chk("t4_ovf", stat_overflow, 1);
        chk("t4_count", stat_count, 32);
        chk("t4_done", stat_done, 1);

        // Reset with a read in flight
        pulse_start();
        send_beat(32'h77, 1'b0, 20, ok);
        send_beat(32'h78, 1'b0, 20, ok);
        ctrl_rd_req = 1'b1; ctrl_rd_addr = 5'd0;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ctrl_rd_gnt) begin
                lat = c;
                break;
            end
        end
        chk("t5_gnt", (lat >= 0 && lat <= 2), 1);
        @(posedge clk); #1;
        ctrl_rd_req = 1'b0; rst = 1'b1;
        vbefore = valid_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", stat_busy, 0);
        chk("t5_tcm_en", tcm_en, 0);
        chk("t5_count", stat_count, 0);
        chk("t5_rd_data", ctrl_rd_data, 0);
        idle_cycles(5);
        chk("t5_no_valid", valid_cnt - vbefore, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tcm_capture_arbiter.md
# tcm_capture_arbiter

Controller for the 32-entry x 32-bit single-port TCM behind the AXI-Stream slave. It sequences a frame capture from the stream into the TCM under control-register command. It also arbitrates the single TCM port between stream writes and register-side readback, so software can read captured words without a second BRAM port. It drives the TCM port directly and replaces the free-running write-enable/address logic of the stream slave.

## Interface
- C_S_AXIS_TDATA_WIDTH, 32, stream and TCM data width
- C_TCM_ADDR_WIDTH, 5, TCM address width; depth = 2**C_TCM_ADDR_WIDTH (32)

- S_AXIS_ACLK  in  1  sole clock, rising edge
- S_AXIS_ARESET  in  1  synchronous, active-high reset
- ctrl_start  in  1  one-cycle pulse: arm a new capture at address 0
- ctrl_rd_req  in  1  readback request, held until ctrl_rd_gnt
- ctrl_rd_addr  in  C_TCM_ADDR_WIDTH  readback address, stable while ctrl_rd_req is high
- ctrl_rd_gnt  out  1  one-cycle grant of the read request
- ctrl_rd_valid  out  1  one-cycle strobe: ctrl_rd_data is valid
- ctrl_rd_data  out  C_S_AXIS_TDATA_WIDTH  readback word, holds its value until the next strobe
- stat_busy  out  1  high in state CAPTURE
- stat_done  out  1  high in state DONE
- stat_overflow  out  1  sticky: capture reached depth without TLAST
- stat_count  out  C_TCM_ADDR_WIDTH+1  words written this capture (0..32)
- S_AXIS_TVALID / S_AXIS_TDATA / S_AXIS_TLAST  in  1/C_S_AXIS_TDATA_WIDTH/1  stream input
- S_AXIS_TREADY  out  1  stream ready
- tcm_en / tcm_we  out  1/1  TCM port enable and write enable
- tcm_addr  out  C_TCM_ADDR_WIDTH  TCM address
- tcm_wdata  out  C_S_AXIS_TDATA_WIDTH  TCM write data
- tcm_rdata  in  C_S_AXIS_TDATA_WIDTH  TCM read data, valid one cycle after tcm_en with tcm_we=0

## Operation
- States are IDLE, CAPTURE and DONE. Reset enters IDLE.
- IDLE -> CAPTURE on ctrl_start. DONE -> CAPTURE on ctrl_start.
- ctrl_start in CAPTURE restarts the capture: write pointer, stat_count and stat_overflow clear, and the state stays CAPTURE.
- CAPTURE -> DONE on an accepted beat with TLAST=1, or on the beat that makes stat_count = 32 (unwrapped build).
- A beat is accepted when TVALID & TREADY. It writes TDATA to the write pointer; then the pointer and stat_count increment.
- S_AXIS_TREADY = (state==CAPTURE) & ~rd_win. It is 0 in IDLE and DONE, so beats stall and nothing is dropped.
- Arbitration is round-robin between read and stream; only one TCM access is issued per cycle.
  - rd_win = ctrl_rd_req & ~rd_pending & (last_owner==STREAM | no valid beat this cycle).
  - After a read grant, the stream owns the next cycle.
  - A held read is granted within 2 cycles. Stream throughput is at worst 1 beat per 2 cycles under continuous reads.
- Reads are granted in every state, one outstanding at a time. ctrl_rd_gnt stays low while rd_pending is set.
- stat_overflow is set on the beat that fills the TCM without TLAST. It clears only on ctrl_start or reset.
- Reset mid-capture aborts with no further TCM writes. Any pending read is dropped, with no ctrl_rd_valid.
- If reset and ctrl_start are asserted in the same cycle, reset wins.

## Timing
- Reset values:
  - S_AXIS_TREADY, ctrl_rd_gnt, ctrl_rd_valid, stat_*, tcm_en and tcm_we = 0.
  - tcm_addr, tcm_wdata and ctrl_rd_data = 0.
- The TCM port is fully registered. A beat accepted or read granted in cycle N drives tcm_en/tcm_we/tcm_addr/tcm_wdata in cycle N+1.
- Read latency: grant in N, TCM command in N+1, tcm_rdata in N+2, ctrl_rd_valid and ctrl_rd_data (registered) in N+3.
- stat_count, stat_done and stat_overflow update in N+1 relative to the beat that causes the change.
- Back-to-back beats are accepted one per cycle when no read is requested.

## Configuration
- TCM_CAPTURE_WRAP_EN defined: the write pointer wraps 31 -> 0 and capture continues until TLAST.
  - stat_overflow sets at the first wrap.
  - stat_count saturates at 32.
- TCM_CAPTURE_WRAP_EN undefined: capture stops at 32 words and enters DONE; stat_overflow is set if the 32nd beat lacked TLAST.

## Structure
- The package tcm_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2);
  - TCM_DEPTH and TCM_ADDR_WIDTH constants;
  - the owner encoding for the round-robin.
- One sub-module, tcm_port_arbiter, contains the round-robin grant and the registered TCM port mux. The FSM and counters stay in the top level.

## Test plan
- Start, then 8 beats 0xA0..0xA7 with TLAST on the 8th -> TCM addresses 0..7 written, stat_done=1, stat_count=8, stat_overflow=0, TREADY=0 afterwards.
- 40 beats with no TLAST, unwrapped build -> 32 writes, stat_count=32, stat_overflow=1, DONE, beats 33..40 stalled.
- Same 40 beats with TCM_CAPTURE_WRAP_EN, TLAST on beat 40 -> addresses 0..7 hold beats 33..40, stat_overflow=1, stat_count=32.
- Continuous TVALID plus ctrl_rd_req held at address 3 -> grant within 2 cycles, ctrl_rd_valid 3 cycles after the grant with the data stored at address 3, no beat lost or duplicated.
- ctrl_start at beat 5 of a capture -> the next beat writes address 0 and stat_count restarts from 1.
- S_AXIS_ARESET asserted with a read pending -> all outputs 0 the next cycle, no ctrl_rd_valid, state IDLE.
